// File: rtl/comparator_4in_bist.sv
// ============================================================================
//  Module   : comparator_4in_bist
//  Brief    : Self-test engine that sweeps all 16 vectors through a 4-input
//             comparator, checks (a==c)&&(b==d) and records the first failure.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module comparator_4in_bist #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] first_fail_vec
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;

    localparam logic [7:0] c_SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0] r_state,          w_state_nxt;
    logic [3:0] r_vec,            w_vec_nxt;
    logic [7:0] r_settle_cnt,     w_settle_cnt_nxt;
    logic [3:0] r_stim,           w_stim_nxt;
    logic       r_busy,           w_busy_nxt;
    logic       r_done,           w_done_nxt;
    logic       r_pass,           w_pass_nxt;
    logic [4:0] r_err_count,      w_err_count_nxt;
    logic       r_fail_valid,     w_fail_valid_nxt;
    logic [3:0] r_first_fail_vec, w_first_fail_vec_nxt;

    logic       w_expected;
    logic       w_mismatch;
    logic [4:0] w_err_inc;

    // Golden comparator function evaluated on the vector currently applied
    assign w_expected = (r_vec[3] == r_vec[1]) && (r_vec[2] == r_vec[0]);
    assign w_mismatch = (dut_out != w_expected);
    assign w_err_inc  = r_err_count + {4'd0, w_mismatch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= c_ST_IDLE;
            r_vec            <= 4'd0;
            r_settle_cnt     <= 8'd0;
            r_stim           <= 4'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= 5'd0;
            r_fail_valid     <= 1'b0;
            r_first_fail_vec <= 4'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_vec            <= w_vec_nxt;
            r_settle_cnt     <= w_settle_cnt_nxt;
            r_stim           <= w_stim_nxt;
            r_busy           <= w_busy_nxt;
            r_done           <= w_done_nxt;
            r_pass           <= w_pass_nxt;
            r_err_count      <= w_err_count_nxt;
            r_fail_valid     <= w_fail_valid_nxt;
            r_first_fail_vec <= w_first_fail_vec_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_vec_nxt            = r_vec;
        w_settle_cnt_nxt     = r_settle_cnt;
        w_stim_nxt           = r_stim;
        w_busy_nxt           = r_busy;
        w_done_nxt           = 1'b0;
        w_pass_nxt           = r_pass;
        w_err_count_nxt      = r_err_count;
        w_fail_valid_nxt     = r_fail_valid;
        w_first_fail_vec_nxt = r_first_fail_vec;

        case (r_state)
            c_ST_IDLE: begin
                w_stim_nxt = 4'd0;
                w_busy_nxt = 1'b0;
                if (start && !abort) begin
                    w_vec_nxt        = 4'd0;
                    w_settle_cnt_nxt = c_SETTLE_RELOAD;
                    w_busy_nxt       = 1'b1;
                    w_err_count_nxt  = 5'd0;
                    w_fail_valid_nxt = 1'b0;
                    w_pass_nxt       = 1'b0;
                    w_state_nxt      = c_ST_SETTLE;
                end
            end

            c_ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_stim_nxt  = 4'd0;
                end else if (r_settle_cnt == 8'd0) begin
                    w_state_nxt = c_ST_SAMPLE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt - 8'd1;
                end
            end

            c_ST_SAMPLE: begin
                if (abort) begin
                    // In-flight sample is dropped; partial error record kept
                    w_state_nxt = c_ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_stim_nxt  = 4'd0;
                end else begin
                    w_err_count_nxt = w_err_inc;
                    if (w_mismatch && !r_fail_valid) begin
                        w_fail_valid_nxt     = 1'b1;
                        w_first_fail_vec_nxt = r_vec;
                    end
                    if (r_vec != 4'd15) begin
                        w_vec_nxt        = r_vec + 4'd1;
                        w_stim_nxt       = r_vec + 4'd1;
                        w_settle_cnt_nxt = c_SETTLE_RELOAD;
                        w_state_nxt      = c_ST_SETTLE;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_stim_nxt  = 4'd0;
                        w_pass_nxt  = (w_err_inc == 5'd0);
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_stim_nxt  = 4'd0;
            end
        endcase
    end

    assign {a, b, c, d}    = r_stim;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign fail_valid      = r_fail_valid;
    assign first_fail_vec  = r_first_fail_vec;

endmodule

`default_nettype wire
